// File: rtl/heap_ctrl_pkg.sv
// Shared types for the heap request arbiter: opcodes, FSM states, response record.
package heap_ctrl_pkg;

   localparam int unsigned RSP_DATA_W = 32;
   localparam int unsigned RSP_RD_W   = 5;

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [RSP_RD_W-1:0]   rd;
      logic [RSP_DATA_W-1:0] data;
      logic                  err;
   } rsp_t;

   // A request may go to the unit only if it cannot over- or under-flow the heap.
   function automatic logic req_legal(input logic [2:0] op, input logic full, input logic empty);
      return ((op == OP_PUSH) && !full) || ((op == OP_POP) && !empty);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: the lane not granted last wins a tie.
module rr_arb2 (
   input  logic       v0,
   input  logic       v1,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (v0 && v1) begin
         gnt = last ? 2'b01 : 2'b10;
      end else if (v0) begin
         gnt = 2'b01;
      end else if (v1) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/heap_req_arbiter.sv
// Shares one heap instruction unit between two lanes: arbitrates, issues one
// operation at a time, tracks occupancy and routes tagged responses back.
module heap_req_arbiter
   import heap_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W  = RSP_DATA_W,
   parameter int unsigned RD_W    = RSP_RD_W,
   parameter int unsigned CAP     = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         base_addr,
   input  logic                      req0_v,
   output logic                      req0_ready,
   input  logic [2:0]                req0_op,
   input  logic [RD_W-1:0]           req0_rd,
   input  logic [DATA_W-1:0]         req0_data,
   input  logic                      req1_v,
   output logic                      req1_ready,
   input  logic [2:0]                req1_op,
   input  logic [RD_W-1:0]           req1_rd,
   input  logic [DATA_W-1:0]         req1_data,
   output logic                      rsp0_v,
   output logic [RD_W-1:0]           rsp0_rd,
   output logic [DATA_W-1:0]         rsp0_data,
   output logic                      rsp0_err,
   output logic                      rsp1_v,
   output logic [RD_W-1:0]           rsp1_rd,
   output logic [DATA_W-1:0]         rsp1_data,
   output logic                      rsp1_err,
   output logic                      heap_in_v,
   output logic [RD_W-1:0]           heap_rd,
   output logic [2:0]                heap_vrd1,
   output logic [2:0]                heap_vrd2,
   output logic [DATA_W-1:0]         heap_in_data,
   output logic [DATA_W-1:0]         heap_in_addr,
   output logic [DATA_W-1:0]         heap_in_size,
   input  logic                      heap_out_v,
   input  logic [DATA_W-1:0]         heap_out_data,
   output logic [$clog2(CAP+1)-1:0]  occupancy
);

   localparam int unsigned OCC_W = $clog2(CAP + 1);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic               lane_q, lane_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OCC_W-1:0]   occ_q, occ_d;

   logic               hin_v_q, hin_v_d;
   logic [RD_W-1:0]    hin_rd_q, hin_rd_d;
   logic [2:0]         hin_op_q, hin_op_d;
   logic [DATA_W-1:0]  hin_data_q, hin_data_d;
   logic [DATA_W-1:0]  hin_addr_q, hin_addr_d;
   logic [DATA_W-1:0]  hin_size_q, hin_size_d;

   rsp_t               rsp_d;
   logic [1:0]         rsp_v_q, rsp_v_d;
   rsp_t               rsp0_q, rsp0_d;
   rsp_t               rsp1_q, rsp1_d;

   logic [1:0]         gnt;
   logic               sel_lane;
   logic [2:0]         sel_op;
   logic [RD_W-1:0]    sel_rd;
   logic [DATA_W-1:0]  sel_data;
   logic               occ_full;
   logic               occ_empty;

   rr_arb2 u_arb (
      .v0   (req0_v),
      .v1   (req1_v),
      .last (last_q),
      .gnt  (gnt)
   );

   assign sel_lane  = gnt[1];
   assign sel_op    = sel_lane ? req1_op   : req0_op;
   assign sel_rd    = sel_lane ? req1_rd   : req0_rd;
   assign sel_data  = sel_lane ? req1_data : req0_data;
   assign occ_full  = (occ_q == OCC_W'(CAP));
   assign occ_empty = (occ_q == '0);

   // Handshake is combinational so a lane learns of its grant in the accept cycle.
   assign req0_ready = (state_q == ST_IDLE) && gnt[0];
   assign req1_ready = (state_q == ST_IDLE) && gnt[1];

   // Next-state and next-output logic; registered outputs load on state entry.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      occ_d      = occ_q;
      hin_v_d    = 1'b0;
      hin_rd_d   = hin_rd_q;
      hin_op_d   = hin_op_q;
      hin_data_d = hin_data_q;
      hin_addr_d = hin_addr_q;
      hin_size_d = hin_size_q;
      rsp_d      = '0;
      rsp_v_d    = 2'b00;

      unique case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               lane_d = sel_lane;
               if (req_legal(sel_op, occ_full, occ_empty)) begin
                  hin_v_d    = 1'b1;
                  hin_rd_d   = sel_rd;
                  hin_op_d   = sel_op;
                  hin_data_d = sel_data;
                  hin_addr_d = base_addr;
                  hin_size_d = DATA_W'(occ_q);
                  state_d    = ST_ISSUE;
               end else begin
                  rsp_d.rd   = RSP_RD_W'(sel_rd);
                  rsp_d.err  = 1'b1;
                  rsp_v_d    = sel_lane ? 2'b10 : 2'b01;
                  state_d    = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A result arriving on the last allowed cycle still counts as success.
            if (heap_out_v) begin
               occ_d      = (hin_op_q == OP_PUSH) ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
               rsp_d.rd   = RSP_RD_W'(hin_rd_q);
               rsp_d.data = (hin_op_q == OP_POP) ? RSP_DATA_W'(heap_out_data) : '0;
               rsp_v_d    = lane_q ? 2'b10 : 2'b01;
               state_d    = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_d.rd   = RSP_RD_W'(hin_rd_q);
               rsp_d.err  = 1'b1;
               rsp_v_d    = lane_q ? 2'b10 : 2'b01;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            last_d  = lane_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rsp0_d = rsp_v_d[0] ? rsp_d : '0;
      rsp1_d = rsp_v_d[1] ? rsp_d : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lane_q     <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         occ_q      <= '0;
         hin_v_q    <= 1'b0;
         hin_rd_q   <= '0;
         hin_op_q   <= '0;
         hin_data_q <= '0;
         hin_addr_q <= '0;
         hin_size_q <= '0;
         rsp_v_q    <= 2'b00;
         rsp0_q     <= '0;
         rsp1_q     <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         occ_q      <= occ_d;
         hin_v_q    <= hin_v_d;
         hin_rd_q   <= hin_rd_d;
         hin_op_q   <= hin_op_d;
         hin_data_q <= hin_data_d;
         hin_addr_q <= hin_addr_d;
         hin_size_q <= hin_size_d;
         rsp_v_q    <= rsp_v_d;
         rsp0_q     <= rsp0_d;
         rsp1_q     <= rsp1_d;
      end
   end

   assign rsp0_v       = rsp_v_q[0];
   assign rsp0_rd      = RD_W'(rsp0_q.rd);
   assign rsp0_data    = DATA_W'(rsp0_q.data);
   assign rsp0_err     = rsp0_q.err;
   assign rsp1_v       = rsp_v_q[1];
   assign rsp1_rd      = RD_W'(rsp1_q.rd);
   assign rsp1_data    = DATA_W'(rsp1_q.data);
   assign rsp1_err     = rsp1_q.err;

   assign heap_in_v    = hin_v_q;
   assign heap_rd      = hin_rd_q;
   assign heap_vrd1    = hin_op_q;
   assign heap_vrd2    = 3'b000;
   assign heap_in_data = hin_data_q;
   assign heap_in_addr = hin_addr_q;
   assign heap_in_size = hin_size_q;
   assign occupancy    = occ_q;

endmodule

// File: tb/tb_heap_req_arbiter.sv
// Directed and randomized bench for heap_req_arbiter with a max-heap unit model.
module tb_heap_req_arbiter;
   import heap_ctrl_pkg::*;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned CAP     = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned OCC_W   = $clog2(CAP + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] base_addr;
   logic              req0_v, req0_ready, req1_v, req1_ready;
   logic [2:0]        req0_op, req1_op;
   logic [RD_W-1:0]   req0_rd, req1_rd;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              rsp0_v, rsp0_err, rsp1_v, rsp1_err;
   logic [RD_W-1:0]   rsp0_rd, rsp1_rd;
   logic [DATA_W-1:0] rsp0_data, rsp1_data;
   logic              heap_in_v;
   logic [RD_W-1:0]   heap_rd;
   logic [2:0]        heap_vrd1, heap_vrd2;
   logic [DATA_W-1:0] heap_in_data, heap_in_addr, heap_in_size;
   logic              heap_out_v = 1'b0;
   logic [DATA_W-1:0] heap_out_data = '0;
   logic [OCC_W-1:0]  occupancy;

   int checks = 0;
   int failures = 0;

   // Environment: heap unit model and reference model state.
   logic [DATA_W-1:0] unit_store[$];
   logic [DATA_W-1:0] unit_res = '0;
   int                unit_pend = 0;
   int                unit_lat = 3;
   int                unit_outs = 0;
   bit                unit_en = 1'b1;
   logic [DATA_W-1:0] ref_heap[$];
   int                ref_occ = 0;
   int                ref_last = 1;

   heap_req_arbiter #(.DATA_W(DATA_W), .RD_W(RD_W), .CAP(CAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .base_addr(base_addr),
      .req0_v(req0_v), .req0_ready(req0_ready), .req0_op(req0_op), .req0_rd(req0_rd), .req0_data(req0_data),
      .req1_v(req1_v), .req1_ready(req1_ready), .req1_op(req1_op), .req1_rd(req1_rd), .req1_data(req1_data),
      .rsp0_v(rsp0_v), .rsp0_rd(rsp0_rd), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_v(rsp1_v), .rsp1_rd(rsp1_rd), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .heap_in_v(heap_in_v), .heap_rd(heap_rd), .heap_vrd1(heap_vrd1), .heap_vrd2(heap_vrd2),
      .heap_in_data(heap_in_data), .heap_in_addr(heap_in_addr), .heap_in_size(heap_in_size),
      .heap_out_v(heap_out_v), .heap_out_data(heap_out_data), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic int max_idx(input logic [DATA_W-1:0] q[$]);
      int m = -1;
      foreach (q[i]) if (m < 0 || q[i] > q[m]) m = i;
      return m;
   endfunction

   // Unit model: answers unit_lat cycles after the issue strobe; push results are junk.
   always @(negedge clk) begin
      heap_out_v    = 1'b0;
      heap_out_data = '0;
      if (unit_pend > 0) begin
         unit_pend--;
         if (unit_pend == 0) begin
            heap_out_v    = 1'b1;
            heap_out_data = unit_res;
            unit_outs++;
         end
      end
      if (heap_in_v === 1'b1 && unit_en) begin
         if (heap_vrd1 == OP_PUSH) begin
            unit_store.push_back(heap_in_data);
            unit_res = DATA_W'($urandom);
         end else if (unit_store.size() > 0) begin
            int mi;
            mi = max_idx(unit_store);
            unit_res = unit_store[mi];
            unit_store.delete(mi);
         end else begin
            unit_res = '0;
         end
         unit_pend = unit_lat;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int lane, input logic v, input logic [2:0] op,
                        input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d);
      if (lane == 0) begin req0_v = v; req0_op = op; req0_rd = rd; req0_data = d; end
      else           begin req1_v = v; req1_op = op; req1_rd = rd; req1_data = d; end
   endtask

   // Starts and ends on a falling edge; returns just after the accepting edge.
   task automatic wait_accept(input int lane);
      bit acc = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) begin
         #1;
         if ((lane != 0 ? req1_ready : req0_ready) === 1'b1) begin
            acc = 1'b1;
            chk("ready_other_lane", lane != 0 ? req0_ready : req1_ready, 0);
            @(posedge clk);
            @(negedge clk);
            if (lane == 0) req0_v = 1'b0; else req1_v = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      chk("accepted", acc, 1);
   endtask

   // Follows one accepted request to its response and checks it against the model.
   task automatic complete(input int lane, input logic [2:0] op,
                           input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] data);
      bit legal, exp_err, got;
      logic [DATA_W-1:0] exp_data;
      int exp_k, k, nin, mi;
      legal    = (op == OP_PUSH && ref_occ < CAP) || (op == OP_POP && ref_occ > 0);
      exp_err  = !legal || !unit_en;
      exp_data = '0;
      if (legal && unit_en && op == OP_POP) exp_data = ref_heap[max_idx(ref_heap)];
      exp_k = !legal ? 1 : (unit_en ? unit_lat + 2 : TIMEOUT + 2);
      k = 1; nin = 0; got = 1'b0;
      while (!got && k <= 200) begin
         chk("ready_while_busy", {req1_ready, req0_ready}, 0);
         chk("rsp_other_lane", lane != 0 ? rsp0_v : rsp1_v, 0);
         if (heap_in_v === 1'b1) begin
            nin++;
            chk("issue_cycle", k, 1);
            chk("heap_vrd1", heap_vrd1, op);
            chk("heap_vrd2", heap_vrd2, 0);
            chk("heap_rd", heap_rd, rd);
            chk("heap_in_data", heap_in_data, data);
            chk("heap_in_addr", heap_in_addr, base_addr);
            chk("heap_in_size", heap_in_size, ref_occ);
         end
         if ((lane != 0 ? rsp1_v : rsp0_v) === 1'b1) begin
            got = 1'b1;
            chk("rsp_cycle", k, exp_k);
            chk("rsp_err", lane != 0 ? rsp1_err : rsp0_err, exp_err);
            chk("rsp_data", lane != 0 ? rsp1_data : rsp0_data, exp_data);
            chk("rsp_rd", lane != 0 ? rsp1_rd : rsp0_rd, rd);
         end else begin
            k++;
            @(negedge clk);
         end
      end
      chk("rsp_seen", got, 1);
      chk("issue_count", nin, legal ? 1 : 0);
      if (legal && unit_en) begin
         if (op == OP_PUSH) begin
            ref_heap.push_back(data);
            ref_occ++;
         end else begin
            mi = max_idx(ref_heap);
            ref_heap.delete(mi);
            ref_occ--;
         end
      end
      ref_last = lane;
      chk("occupancy", occupancy, ref_occ);
   endtask

   task automatic run_req(input int lane, input logic [2:0] op,
                          input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d);
      drive(lane, 1'b1, op, rd, d);
      wait_accept(lane);
      complete(lane, op, rd, d);
   endtask

   task automatic run_pair(input int first,
                           input logic [2:0] op_f, input logic [RD_W-1:0] rd_f, input logic [DATA_W-1:0] d_f,
                           input logic [2:0] op_s, input logic [RD_W-1:0] rd_s, input logic [DATA_W-1:0] d_s);
      drive(first, 1'b1, op_f, rd_f, d_f);
      drive(1 - first, 1'b1, op_s, rd_s, d_s);
      wait_accept(first);
      complete(first, op_f, rd_f, d_f);
      wait_accept(1 - first);
      complete(1 - first, op_s, rd_s, d_s);
   endtask

   function automatic logic [2:0] rand_op();
      int r = int'($urandom_range(0, 9));
      if (r < 5) return OP_PUSH;
      if (r < 9) return OP_POP;
      return 3'($urandom_range(2, 7));
   endfunction

   initial begin
      int outs0;
      logic [DATA_W-1:0] vals[3];
      reset = 1'b1;
      base_addr = 32'h8000_1000;
      drive(0, 1'b0, 3'b000, '0, '0);
      drive(1, 1'b0, 3'b000, '0, '0);
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_rsp_v", {rsp1_v, rsp0_v}, 0);
      chk("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
      chk("rst_rsp_data", {rsp1_data, rsp0_data}, 0);
      chk("rst_rsp_rd", {rsp1_rd, rsp0_rd}, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_heap_in_v", heap_in_v, 0);
      chk("rst_heap_fields", {heap_rd, heap_vrd1, heap_vrd2}, 0);
      chk("rst_heap_data", {heap_in_data, heap_in_addr}, 0);
      chk("rst_heap_size", heap_in_size, 0);
      chk("rst_occupancy", occupancy, 0);
      reset = 1'b0;
      @(negedge clk);

      // Lane 0 pushes three values, then pops the maximum
      vals = '{32'd10, 32'd20, 32'd15};
      foreach (vals[i]) run_req(0, OP_PUSH, RD_W'(i + 1), vals[i]);
      chk("occ_after_3_push", occupancy, 3);
      run_req(0, OP_POP, 5'd4, '0);
      chk("occ_after_pop", occupancy, 2);

      // Simultaneous requests after lane 0 was served: lane 1 first
      run_pair(1, OP_POP, 5'd7, '0, OP_POP, 5'd9, '0);

      // Pop on empty is rejected without touching the unit
      run_req(0, OP_POP, 5'd11, '0);

      // Fill to capacity, then overflow
      for (int i = 0; i < int'(CAP); i++) run_req(i % 2, OP_PUSH, RD_W'(i), DATA_W'($urandom));
      run_req(0, OP_PUSH, 5'd30, 32'h1234);
      chk("occ_full", occupancy, CAP);

      // Unit never answers: timeout, then normal service resumes
      unit_en = 1'b0;
      run_req(1, OP_POP, 5'd12, '0);
      unit_en = 1'b1;
      run_req(0, OP_POP, 5'd13, '0);

      // Reset while waiting; the late unit answer must be ignored
      unit_lat = 6;
      outs0 = unit_outs;
      drive(0, 1'b1, OP_PUSH, 5'd3, 32'd55);
      wait_accept(0);
      chk("rst_test_issue", heap_in_v, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("post_rst_rsp_v", {rsp1_v, rsp0_v}, 0);
         chk("post_rst_occ", occupancy, 0);
         @(negedge clk);
      end
      chk("late_out_v_delivered", unit_outs - outs0, 1);
      unit_store.delete();
      ref_heap.delete();
      ref_occ = 0;
      ref_last = 1;
      unit_lat = 3;
      drive(0, 1'b1, OP_PUSH, 5'd14, 32'd77);
      #1 chk("idle_after_reset", req0_ready, 1);
      wait_accept(0);
      complete(0, OP_PUSH, 5'd14, 32'd77);

      // Randomized traffic against the reference model
      for (int n = 0; n < 60; n++) begin
         unit_lat = int'($urandom_range(1, 5));
         if (n % 5 == 4)
            run_pair(ref_last == 0 ? 1 : 0,
                     rand_op(), RD_W'($urandom), DATA_W'($urandom),
                     rand_op(), RD_W'($urandom), DATA_W'($urandom));
         else
            run_req(int'($urandom_range(0, 1)), rand_op(), RD_W'($urandom), DATA_W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
